// File: rtl/keypad_digit_entry_if.sv
// Keypad entry bus between the microwave controller and keypad_digit_entry.
//   keypad       : raw 10-line key pad, bit k = key k pressed (asynchronous)
//   enable_entry : controller idle and accepting digits
//   entry_reset  : cancel the current entry session
//   load         : one-cycle pulse, timer shifts in data_out
//   data_out     : BCD digit of the last accepted press
//   reject       : one-cycle pulse when a debounced press is refused
//   digit_count  : digits accepted in the current session
interface keypad_digit_entry_if;
  logic [9:0] keypad;
  logic       enable_entry;
  logic       entry_reset;
  logic       load;
  logic [3:0] data_out;
  logic       reject;
  logic [1:0] digit_count;

  modport master (
    output keypad, enable_entry, entry_reset,
    input  load, data_out, reject, digit_count
  );

  modport slave (
    input  keypad, enable_entry, entry_reset,
    output load, data_out, reject, digit_count
  );
endinterface

// File: rtl/keypad_digit_entry.sv
// Keypad digit entry front end for the countdown timer load port.
// Synchronises and debounces a 10-key pad, encodes each accepted press to
// BCD and pulses load. A shadow of the timer's units/tens/minutes shift
// chain rejects digits that would give an illegal ten-seconds digit or
// overflow the digit count.
//   clk   : system clock, rising edge
//   clear : synchronous active-high reset, highest priority
//   bus   : keypad_digit_entry_if.slave (see interface header)
module keypad_digit_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned MAX_DIGITS      = 3
) (
  input logic                  clk,
  input logic                  clear,
  keypad_digit_entry_if.slave  bus
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] DEBOUNCE = 2'd1;
  localparam logic [1:0] HOLD     = 2'd2;
  localparam logic [1:0] RELEASE  = 2'd3;

  // Both debounce and release use "cnt reached the last sample" as the exit
  // test; >= keeps DEBOUNCE_CYCLES=1 working (evaluate right after capture).
  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic [1:0] state;
  logic [9:0] sync1;
  logic [9:0] key_s;
  logic [9:0] cap;
  logic [7:0] cnt;
  logic [3:0] sh_u;
  logic [3:0] sh_t;
  logic [3:0] sh_m;
  logic       load_r;
  logic       reject_r;
  logic [3:0] data_r;
  logic [1:0] count_r;

  logic       key_valid;
  logic [3:0] digit_val;
  logic       evaluate;
  logic       ok;

  assign bus.load        = load_r;
  assign bus.reject      = reject_r;
  assign bus.data_out    = data_r;
  assign bus.digit_count = count_r;

  // Exactly one key down: nonzero with no second bit set.
  assign key_valid = (key_s != '0) && ((key_s & (key_s - 10'd1)) == '0);

  always_comb begin
    digit_val = '0;
    for (int unsigned k = 0; k < 10; k++) begin
      if (cap[k]) digit_val = 4'(k);
    end
  end

  assign evaluate = (state == DEBOUNCE) && (key_s == cap) && (cnt >= CNT_LAST);

  // A new digit pushes the current units digit into the tens position, so a
  // units shadow above 5 would make the ten-seconds digit illegal.
  assign ok = bus.enable_entry
            && (32'(count_r) < MAX_DIGITS)
            && !((count_r != 2'd0) && (sh_u > 4'd5));

  always_ff @(posedge clk) begin
    if (clear) begin
      state    <= IDLE;
      sync1    <= '0;
      key_s    <= '0;
      cap      <= '0;
      cnt      <= '0;
      sh_u     <= '0;
      sh_t     <= '0;
      sh_m     <= '0;
      load_r   <= 1'b0;
      reject_r <= 1'b0;
      data_r   <= '0;
      count_r  <= '0;
    end else begin
      sync1    <= bus.keypad;
      key_s    <= sync1;
      load_r   <= 1'b0;
      reject_r <= 1'b0;

      case (state)
        IDLE: begin
          if (key_valid) begin
            cap   <= key_s;
            cnt   <= 8'd1;
            state <= DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (key_s == cap) begin
            if (cnt >= CNT_LAST) state <= HOLD;
            else                 cnt   <= cnt + 8'd1;
          end else begin
            state <= IDLE;
          end
        end
        HOLD: begin
          if (key_s == '0) begin
            cnt   <= 8'd1;
            state <= RELEASE;
          end
        end
        RELEASE: begin
          if (key_s != '0)           state <= HOLD;
          else if (cnt >= CNT_LAST)  state <= IDLE;
          else                       cnt   <= cnt + 8'd1;
        end
        default: state <= IDLE;
      endcase

      // entry_reset beats a coincident acceptance: the press is refused.
      if (evaluate) begin
        if (ok && !bus.entry_reset) begin
          load_r  <= 1'b1;
          data_r  <= digit_val;
          sh_m    <= sh_t;
          sh_t    <= sh_u;
          sh_u    <= digit_val;
          count_r <= count_r + 2'd1;
        end else begin
          reject_r <= 1'b1;
        end
      end

      if (bus.entry_reset) begin
        count_r <= '0;
        sh_u    <= '0;
        sh_t    <= '0;
        sh_m    <= '0;
      end
    end
  end

endmodule
